// File: rtl/tristate_bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// tristate_bus_pkg
// Shared definitions for the tristate bus arbiter slice.
//   - arbState_t : FSM state encoding (ST_IDLE / ST_GRANT / ST_TURN)
//   - idWidth()  : index width for a given requester count (minimum 1 bit)
//   - OWNER_W_DEFAULT : owner_id width for the default 4-requester build
// ---------------------------------------------------------------------------
package tristate_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } arbState_t;

    // Width needed to index n items; a single item still needs one bit.
    function automatic int idWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int OWNER_W_DEFAULT = 2;

endpackage

// File: rtl/tristate_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// tristate_bus_arbiter_if
// Bundles the request/grant/enable signals of the shared tristate bus.
//   req      : level request per requester (requester -> arbiter)
//   lock     : tenure lock, only present when ARB_LOCK_EN is defined
//   gnt      : one-hot grant (arbiter -> requesters)
//   oe_n     : active-low tristate buffer enables, equal to ~gnt
//   owner_id : index of current/last owner, drives the datapath select mux
//   bus_busy : high while any grant is active
// Modports: master = arbiter side, slave = requester/datapath side.
// ---------------------------------------------------------------------------
interface tristate_bus_arbiter_if
    import tristate_bus_pkg::*;
#(
    parameter int N_REQ = 4
) ();

    localparam int ID_W = idWidth(N_REQ);

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [N_REQ-1:0] oe_n;
    logic [ID_W-1:0]  owner_id;
    logic             bus_busy;
`ifdef ARB_LOCK_EN
    logic             lock;
`endif

    modport master (
        input  req,
`ifdef ARB_LOCK_EN
        input  lock,
`endif
        output gnt,
        output oe_n,
        output owner_id,
        output bus_busy
    );

    modport slave (
        output req,
`ifdef ARB_LOCK_EN
        output lock,
`endif
        input  gnt,
        input  oe_n,
        input  owner_id,
        input  bus_busy
    );

endinterface

// File: rtl/tristate_bus_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational rotate-priority encoder. Finds the first set bit of i_req
// searching i_ptr, i_ptr+1 ... N_REQ-1, 0 ... i_ptr-1.
//   i_req   : request vector
//   i_ptr   : starting search position
//   o_found : any request set
//   o_idx   : index of the winning request (0 when none)
// ---------------------------------------------------------------------------
module rr_picker
    import tristate_bus_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = OWNER_W_DEFAULT
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    output logic             o_found,
    output logic [ID_W-1:0]  o_idx
);

    logic [ID_W-1:0] w_cand;

    // Walk the positions in rotated order and latch onto the first hit.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_cand  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_cand = ID_W'((int'(i_ptr) + i) % N_REQ);
            if (!o_found && i_req[w_cand]) begin
                o_found = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tristate_bus_arbiter
// Round-robin sequencer for a single-wire tristate bus. Owns every buffer
// enable, guarantees at most one driver, inserts TURN_CYC all-off cycles
// between owners and limits each tenure to HOLD_MAX cycles when others wait.
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : tristate_bus_arbiter_if.master (req/lock in, gnt/oe_n/owner_id/
//           bus_busy out, all outputs registered)
// Optional feature macro: ARB_LOCK_EN adds bus.lock, which suppresses
// hold-limit preemption while high during a grant.
// ---------------------------------------------------------------------------
module tristate_bus_arbiter
    import tristate_bus_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int HOLD_MAX = 8,
    parameter int TURN_CYC = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    tristate_bus_arbiter_if.master bus
);

    localparam int ID_W  = idWidth(N_REQ);
    localparam int CNT_W = $clog2(HOLD_MAX + 1);
    localparam int TRN_W = idWidth(TURN_CYC);

    arbState_t        r_state, w_nextState;
    logic [ID_W-1:0]  r_ptr, w_nextPtr;
    logic [ID_W-1:0]  r_owner, w_nextOwner;
    logic [CNT_W-1:0] r_holdCnt, w_nextHoldCnt;
    logic [TRN_W-1:0] r_turnCnt, w_nextTurnCnt;
    logic [N_REQ-1:0] r_gnt, w_nextGnt, r_oeN;
    logic             r_busy;

    logic             w_pickFound;
    logic [ID_W-1:0]  w_pickIdx;
    logic [ID_W-1:0]  w_ptrInc;
    logic             w_lock, w_release, w_others, w_holdHit, w_turnLast;

    rr_picker #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) uPicker (
        .i_req   (bus.req),
        .i_ptr   (r_ptr),
        .o_found (w_pickFound),
        .o_idx   (w_pickIdx)
    );

`ifdef ARB_LOCK_EN
    assign w_lock = bus.lock;
`else
    assign w_lock = 1'b0;
`endif

    assign w_release  = ~bus.req[r_owner];
    assign w_others   = |(bus.req & ~r_gnt);
    assign w_holdHit  = (r_holdCnt == CNT_W'(HOLD_MAX));
    assign w_turnLast = (r_turnCnt == TRN_W'(TURN_CYC - 1));
    assign w_ptrInc   = (r_owner == ID_W'(N_REQ - 1)) ? '0 : r_owner + 1'b1;

    // State and output registers; enables are loaded with the inverse of the
    // next grant so oe_n comes straight from flops and can never disagree.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_owner   <= '0;
            r_holdCnt <= '0;
            r_turnCnt <= '0;
            r_gnt     <= '0;
            r_oeN     <= '1;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_ptr     <= w_nextPtr;
            r_owner   <= w_nextOwner;
            r_holdCnt <= w_nextHoldCnt;
            r_turnCnt <= w_nextTurnCnt;
            r_gnt     <= w_nextGnt;
            r_oeN     <= ~w_nextGnt;
            r_busy    <= |w_nextGnt;
        end
    end

    // Next-state and counter logic. Release wins over hold expiry simply
    // because both lead to the same TURN transition.
    always_comb begin
        w_nextState   = r_state;
        w_nextPtr     = r_ptr;
        w_nextHoldCnt = r_holdCnt;
        w_nextTurnCnt = r_turnCnt;
        case (r_state)
            ST_IDLE: begin
                if (w_pickFound) begin
                    w_nextState   = ST_GRANT;
                    w_nextHoldCnt = CNT_W'(1);
                end
            end
            ST_GRANT: begin
                if (w_release || (w_holdHit && w_others && !w_lock)) begin
                    w_nextState   = ST_TURN;
                    w_nextPtr     = w_ptrInc;
                    w_nextHoldCnt = '0;
                    w_nextTurnCnt = '0;
                end else if (w_holdHit) begin
                    // Alone on the bus: start a fresh window; locked: saturate.
                    w_nextHoldCnt = w_lock ? r_holdCnt : CNT_W'(1);
                end else begin
                    w_nextHoldCnt = r_holdCnt + 1'b1;
                end
            end
            ST_TURN: begin
                if (w_turnLast) begin
                    w_nextTurnCnt = '0;
                    if (w_pickFound) begin
                        w_nextState   = ST_GRANT;
                        w_nextHoldCnt = CNT_W'(1);
                    end else begin
                        w_nextState = ST_IDLE;
                    end
                end else begin
                    w_nextTurnCnt = r_turnCnt + 1'b1;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Grant/owner decode: a new tenure takes the picker result, an ongoing
    // one keeps its grant, and any other state drives nothing while owner_id
    // keeps pointing at the last owner for the datapath mux.
    always_comb begin
        w_nextGnt   = '0;
        w_nextOwner = r_owner;
        if (w_nextState == ST_GRANT) begin
            if (r_state == ST_GRANT) begin
                w_nextGnt = r_gnt;
            end else begin
                w_nextGnt[w_pickIdx] = 1'b1;
                w_nextOwner          = w_pickIdx;
            end
        end
    end

    assign bus.gnt      = r_gnt;
    assign bus.oe_n     = r_oeN;
    assign bus.owner_id = r_owner;
    assign bus.bus_busy = r_busy;

endmodule
